// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default geometry and lane offset helper for the row feeder
//   Types: state_t (IDLE/FETCH/WAIT/STREAM/DONE)
//   Defaults: DW_DEF, ADDR_DW_DEF, ROWS_DEF, K_LEN_DEF
//   Helper: lane_off(r, dw) gives the LSB of lane r in the packed west-edge bus
package sa_pkg;

    localparam int DW_DEF      = 8;
    localparam int ADDR_DW_DEF = 4;
    localparam int ROWS_DEF    = 4;
    localparam int K_LEN_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        STREAM,
        DONE
    } state_t;

    function automatic int lane_off(input int r, input int dw);
        return r * dw;
    endfunction

endpackage

// File: rtl/sa_row_feeder_skew_lane.sv
// skew_lane: one row of the tile buffer; presents element (t - R) of its row, or zero outside the window
//   clk, rst        clock, asynchronous active-high reset (clears the row)
//   wr_en, wr_col   capture strobe and column for wr_data
//   wr_data         operand from the RAM read port
//   t               current stream beat
//   lane_data       skewed element for this row, zero-padded
module skew_lane #(
    parameter int DW    = 8,
    parameter int K_LEN = 4,
    parameter int R     = 0,
    parameter int TW    = 3,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic [TW-1:0] t,
    output logic [DW-1:0] lane_data
);

    logic [DW-1:0] row_q [K_LEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < K_LEN; c++) row_q[c] <= '0;
        end else if (wr_en) begin
            row_q[wr_col] <= wr_data;
        end
    end

    // Row R lags the array edge by R beats, so column c appears at beat c + R.
    always_comb begin
        lane_data = '0;
        for (int c = 0; c < K_LEN; c++)
            if (int'(t) == c + R) lane_data = row_q[c];
    end

endmodule

// File: rtl/sa_row_feeder.sv
// sa_row_feeder: fetches a ROWS x K_LEN tile from the operand RAM and streams it skewed into the systolic array
//   clk, rst            clock, asynchronous active-high reset
//   start, base_addr    tile request and address of element (0,0)
//   mem_init            RAM initialising; kills an in-flight fetch
//   ram_dout            RAM read data (one cycle after the registered issue)
//   ram_ren, ram_addr   registered RAM read port
//   busy, done, abort   request status
//   sa_valid, sa_data   west-edge stream, lane r at [r*DW +: DW]
module sa_row_feeder
    import sa_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int ADDR_DW = ADDR_DW_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int K_LEN   = K_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_DW-1:0]   base_addr,
    input  logic                 mem_init,
    input  logic [DW-1:0]        ram_dout,
    output logic                 ram_ren,
    output logic [ADDR_DW-1:0]   ram_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic                 sa_valid,
    output logic [ROWS*DW-1:0]   sa_data
);

    localparam int N  = ROWS * K_LEN;
    localparam int T  = K_LEN + ROWS - 1;
    localparam int TW = $clog2(T + 1);
    localparam int CW = K_LEN > 1 ? $clog2(K_LEN) : 1;
    localparam logic [ADDR_DW-1:0] LAST  = ADDR_DW'(N - 1);
    localparam logic [TW-1:0]      TLAST = TW'(T - 1);

    state_t               state;
    logic [ADDR_DW-1:0]   base_q;
    logic [ADDR_DW-1:0]   cnt;
    logic                 p1_v, p2_v;
    logic [ADDR_DW-1:0]   p1_i, p2_i;
    logic [TW-1:0]        t;
    logic [ADDR_DW-1:0]   wr_row;
    logic [CW-1:0]        wr_col;
    logic [ROWS*DW-1:0]   lanes;

    // Stage 2 of the issue pipeline lines up with the RAM's data for that index.
    assign wr_row = ADDR_DW'(p2_i / K_LEN);
    assign wr_col = CW'(p2_i % K_LEN);

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        skew_lane #(
            .DW(DW),
            .K_LEN(K_LEN),
            .R(r),
            .TW(TW),
            .CW(CW)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .wr_en(p2_v && wr_row == ADDR_DW'(r)),
            .wr_col(wr_col),
            .wr_data(ram_dout),
            .t(t),
            .lane_data(lanes[lane_off(r, DW) +: DW])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            cnt      <= '0;
            p1_v     <= 1'b0;
            p1_i     <= '0;
            p2_v     <= 1'b0;
            p2_i     <= '0;
            t        <= '0;
            ram_ren  <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            sa_valid <= 1'b0;
            sa_data  <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            p1_v  <= 1'b0;
            p2_v  <= p1_v;
            p2_i  <= p1_i;
            case (state)
                IDLE: begin
                    if (start && !mem_init) begin
                        base_q <= base_addr;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_init) begin
                        ram_ren <= 1'b0;
                        p2_v    <= 1'b0;
                        abort   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ram_ren  <= 1'b1;
                        ram_addr <= base_q + cnt;
                        p1_v     <= 1'b1;
                        p1_i     <= cnt;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST) state <= WAIT;
                    end
                end
                WAIT: begin
                    ram_ren <= 1'b0;
                    if (mem_init) begin
                        p2_v  <= 1'b0;
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (p2_v && p2_i == LAST) begin
                        t     <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    sa_valid <= 1'b1;
                    sa_data  <= lanes;
                    t        <= t + 1'b1;
                    if (t == TLAST) state <= DONE;
                end
                DONE: begin
                    sa_valid <= 1'b0;
                    sa_data  <= '0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sa_row_feeder.md
# sa_row_feeder

Downstream consumer of the on-chip operand RAM. It fetches a ROWS×K_LEN operand tile stored row-major in the RAM, buffers it, then streams it into the systolic array's west edge with the diagonal skew the array needs. Row r is delayed r cycles and zero-padded outside its window. It drives the RAM's read port (`ram_addr`, `ram_ren`) and watches the RAM's initialisation flag.

## Interface
Parameters:
- `DW`, 8, operand width (signed two's complement)
- `ADDR_DW`, 4, RAM address width
- `ROWS`, 4, systolic array rows (feeder lanes)
- `K_LEN`, 4, elements per row per tile; `ROWS*K_LEN <= 2**ADDR_DW`

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to load and stream a tile
- `base_addr`  in  ADDR_DW  RAM address of tile element (0,0); sampled with `start`
- `mem_init`  in  1  RAM is initialising (RAM's `mem_initial_signal`)
- `ram_dout`  in  DW  RAM read data, signed
- `ram_ren`  out  1  RAM read enable (registered)
- `ram_addr`  out  ADDR_DW  RAM read address (registered)
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last stream cycle
- `abort`  out  1  one-cycle pulse when a fetch is killed by `mem_init`
- `sa_valid`  out  1  stream beat valid
- `sa_data`  out  ROWS*DW  lane r at bits [r*DW +: DW], signed

## Operation
- States: IDLE, FETCH, WAIT, STREAM, DONE.
- IDLE: `start`=1 and `mem_init`=0 → latch `base_addr`, clear issue counter `i`, enter FETCH. `start` with `mem_init`=1 is ignored. `start` outside IDLE is ignored.
- FETCH: each cycle `ram_ren`←1 and `ram_addr`←(base+i) mod 2**ADDR_DW, with `i` incrementing. After i = N−1 (N=ROWS*K_LEN), go to WAIT.
- Capture: a 2-deep shift pipeline carries (valid, index) alongside each issue. When stage-2 is valid, `ram_dout` is written to buffer[index/K_LEN][index%K_LEN].
- WAIT: `ram_ren`←0. Stay until the last index is captured, then enter STREAM with stream counter t=0.
- STREAM: `sa_valid`=1 for T = K_LEN+ROWS−1 beats.
  - Lane r outputs buffer[r][t−r] when 0 ≤ t−r < K_LEN, else 0.
  - After beat t=T−1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `mem_init`=1 in FETCH or WAIT → `ram_ren`←0, flush the capture pipeline, pulse `abort`, go to IDLE. The buffer contents are don't-care.
- `mem_init` during STREAM is ignored, because the data is already buffered.
- No arithmetic on data; values pass through bit-exact, sign preserved.

## Timing
- Reset values: `ram_ren`=0, `ram_addr`=0, `busy`=0, `done`=0, `abort`=0, `sa_valid`=0, `sa_data`=0, state IDLE, buffer cleared.
- RAM read latency:
  - Issue registered at edge e.
  - RAM updates `dout` at edge e+1.
  - Feeder captures at edge e+2.
- Cycle budget, with `start` sampled at edge 0:
  - Issues occupy edges 1..N.
  - Last capture at edge N+2.
  - First `sa_valid` beat is registered at edge N+3.
  - Beats run to edge N+2+T.
  - `done` is at edge N+3+T.
  - `busy` falls with `done`.
- `abort` is asserted the edge after `mem_init` is first seen high in FETCH/WAIT.
- Back-to-back: a `start` in the cycle right after `done` is accepted.
- Address wrap: base=14, ADDR_DW=4 issues 14, 15, 0, 1, …

## Structure
- Shared package `sa_pkg`:
  - state enum (IDLE/FETCH/WAIT/STREAM/DONE)
  - `DW`, `ROWS`, `K_LEN` defaults
  - a function for the lane offset `r*DW`
- One sub-module: `skew_lane`, one per row. It holds K_LEN entries and is given t and its row index r. It outputs the element or 0.

## Test plan
- Reset mid-STREAM (assert `rst` at beat 2) → all outputs 0 immediately, state IDLE; a following `start` runs normally.
- RAM filled by init with para=0 (mem[i] = (i*5+1)%5 if i%3==0 else −((i*3+1)%5)); `start`, base=0, ROWS=K_LEN=4:
  - beat 0 lane0 = mem[0] = 1, other lanes 0
  - beat 3 lanes = {mem[3], mem[6], mem[9], mem[12]}
  - 7 beats total
  - `done` at edge 26
- base=14 → addresses 14, 15, 0 … 13 observed on `ram_addr`. Beat 0 lane0 = mem[14] = −3 (sign preserved on the bus).
- `mem_init` pulsed during FETCH at issue 5 → `ram_ren` drops next edge, `abort` one-cycle pulse, no `sa_valid`, `busy`=0.
- `start` while `mem_init`=1, then `start` during STREAM → both ignored; exactly one tile is streamed from the accepted request.
